// File: rtl/keypad_pkg.sv
// Shared types, sizes and helpers for the 4x4 keypad scanner.
// Row vectors are active-low: a 0 bit means that row is pulled down.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int KEY_W    = 4;

  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  function automatic logic single_hit(
    input logic [NUM_ROWS-1:0] rows
  );
    int n;
    n = 0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      if (!rows[i]) n++;
    end
    return (n == 1);
  endfunction

  function automatic logic [1:0] hit_row(
    input logic [NUM_ROWS-1:0] rows
  );
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [NUM_COLS-1:0] col_drive(
    input logic [1:0] idx
  );
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_scanner_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad rows.
// Both stages reset to RST_VAL so no phantom hit appears after reset.
module row_sync #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clock_50m,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clock_50m) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column drive, debounce and press events.
// All decisions happen on scan_tick cycles; outputs are registered.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic                clock_50m,
  input  logic                rst,
  input  logic                scan_tick,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam logic [3:0] DB = 4'(DEBOUNCE_TICKS);

  logic [NUM_ROWS-1:0] rows_s;

  state_t     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic [KEY_W-1:0] code_d;
  logic       valid_d;
  logic       held_d;
  logic       hit;
  logic       idle;
  logic [1:0] hrow;

  row_sync #(
    .W       (NUM_ROWS),
    .RST_VAL ({NUM_ROWS{1'b1}})
  ) u_row_sync (
    .clock_50m (clock_50m),
    .rst       (rst),
    .d         (row_in),
    .q         (rows_s)
  );

  assign hit     = single_hit(rows_s);
  assign hrow    = hit_row(rows_s);
  assign idle    = (rows_s == {NUM_ROWS{1'b1}});
  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = key_code;
    valid_d = 1'b0;
    held_d  = key_held;
    if (scan_tick) begin
      unique case (state_q)
        SCAN: begin
          if (hit) begin
            row_d = hrow;
            cnt_d = 4'd1;
            if (DB == 4'd1) begin
              code_d  = {hrow, col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (hit && hrow == row_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB) begin
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              state_d = HELD;
            end
          end else begin
            // Bounce: retry the same column rather than moving on
            cnt_d   = 4'd0;
            state_d = SCAN;
          end
        end
        HELD: begin
          if (idle) begin
            cnt_d = 4'd1;
            if (DB == 4'd1) begin
              cnt_d   = 4'd0;
              held_d  = 1'b0;
              col_d   = col_q + 2'd1;
              state_d = SCAN;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (idle) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB) begin
              cnt_d   = 4'd0;
              held_d  = 1'b0;
              col_d   = col_q + 2'd1;
              state_d = SCAN;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = HELD;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clock_50m) begin
    if (rst) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      cnt_q     <= 4'd0;
      col_out   <= COL_RESET;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      col_out   <= col_drive(col_d);
      key_code  <= code_d;
      key_valid <= valid_d;
      key_held  <= held_d;
    end
  end

endmodule
